// File: rtl/bram2_port_arbiter_if.sv
// rtl/bram2_port_arbiter_if.sv - requester and RAM-port signal bundle for bram2_port_arbiter
// slave = arbiter view, master = the requesters plus the BRAM2 port on the far side.
interface bram2_port_arbiter_if #(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1
);
    logic                  REQ0_VALID;
    logic                  REQ0_READY;
    logic                  REQ0_WE;
    logic [ADDR_WIDTH-1:0] REQ0_ADDR;
    logic [DATA_WIDTH-1:0] REQ0_DATA;
    logic                  RSP0_VALID;
    logic [DATA_WIDTH-1:0] RSP0_DATA;

    logic                  REQ1_VALID;
    logic                  REQ1_READY;
    logic                  REQ1_WE;
    logic [ADDR_WIDTH-1:0] REQ1_ADDR;
    logic [DATA_WIDTH-1:0] REQ1_DATA;
    logic                  RSP1_VALID;
    logic [DATA_WIDTH-1:0] RSP1_DATA;

    logic                  RAM_EN;
    logic                  RAM_WE;
    logic [ADDR_WIDTH-1:0] RAM_ADDR;
    logic [DATA_WIDTH-1:0] RAM_DI;
    logic [DATA_WIDTH-1:0] RAM_DO;

    modport slave (
        input  REQ0_VALID, REQ0_WE, REQ0_ADDR, REQ0_DATA,
        input  REQ1_VALID, REQ1_WE, REQ1_ADDR, REQ1_DATA,
        input  RAM_DO,
        output REQ0_READY, RSP0_VALID, RSP0_DATA,
        output REQ1_READY, RSP1_VALID, RSP1_DATA,
        output RAM_EN, RAM_WE, RAM_ADDR, RAM_DI
    );

    modport master (
        output REQ0_VALID, REQ0_WE, REQ0_ADDR, REQ0_DATA,
        output REQ1_VALID, REQ1_WE, REQ1_ADDR, REQ1_DATA,
        output RAM_DO,
        input  REQ0_READY, RSP0_VALID, RSP0_DATA,
        input  REQ1_READY, RSP1_VALID, RSP1_DATA,
        input  RAM_EN, RAM_WE, RAM_ADDR, RAM_DI
    );
endinterface

// File: rtl/bram2_port_arbiter.sv
// rtl/bram2_port_arbiter.sv - two-requester arbiter in front of one BRAM2 port, read tag tracking
// Optional BRAM2_ARB_FIXED_PRIO_EN: requester 0 always wins a conflict, no PRI register.
module bram2_port_arbiter #(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1,
    parameter int PIPELINED  = 0
) (
    input logic                CLK,
    input logic                RST,
    bram2_port_arbiter_if.slave bus
);
    localparam int L = (PIPELINED != 0) ? 2 : 1;

    logic                  grant0;
    logic                  grant1;
    logic                  rd_push;
    logic                  we_mux;
    logic [ADDR_WIDTH-1:0] addr_mux;
    logic [DATA_WIDTH-1:0] di_mux;
    logic [L-1:0]          tag_v_q;
    logic [L-1:0]          tag_v_d;
    logic [L-1:0]          tag_id_q;
    logic [L-1:0]          tag_id_d;

`ifdef BRAM2_ARB_FIXED_PRIO_EN
    always_comb begin
        grant0 = ~RST & bus.REQ0_VALID;
        grant1 = ~RST & bus.REQ1_VALID & ~bus.REQ0_VALID;
    end
`else
    logic pri_q;
    logic pri_d;

    // Gating with RST keeps READY/EN low for the whole asynchronous reset window.
    always_comb begin
        grant0 = ~RST & bus.REQ0_VALID & (~bus.REQ1_VALID | ~pri_q);
        grant1 = ~RST & bus.REQ1_VALID & (~bus.REQ0_VALID | pri_q);
        pri_d  = pri_q;
        if (grant0) begin
            pri_d = 1'b1;
        end else if (grant1) begin
            pri_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pri_q <= 1'b0;
        end else begin
            pri_q <= pri_d;
        end
    end
`endif

    always_comb begin
        we_mux   = 1'b0;
        addr_mux = bus.REQ0_ADDR;
        di_mux   = bus.REQ0_DATA;
        if (grant1) begin
            we_mux   = bus.REQ1_WE;
            addr_mux = bus.REQ1_ADDR;
            di_mux   = bus.REQ1_DATA;
        end else if (grant0) begin
            we_mux   = bus.REQ0_WE;
        end
    end

    // Tag pipeline mirrors the RAM read latency; the tail lines up with RAM_DO.
    always_comb begin
        rd_push     = (grant0 & ~bus.REQ0_WE) | (grant1 & ~bus.REQ1_WE);
        tag_v_d     = '0;
        tag_id_d    = '0;
        tag_v_d[0]  = rd_push;
        tag_id_d[0] = grant1;
        for (int i = 1; i < L; i++) begin
            tag_v_d[i]  = tag_v_q[i-1];
            tag_id_d[i] = tag_id_q[i-1];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tag_v_q  <= '0;
            tag_id_q <= '0;
        end else begin
            tag_v_q  <= tag_v_d;
            tag_id_q <= tag_id_d;
        end
    end

    assign bus.REQ0_READY = grant0;
    assign bus.REQ1_READY = grant1;
    assign bus.RAM_EN     = grant0 | grant1;
    assign bus.RAM_WE     = we_mux;
    assign bus.RAM_ADDR   = addr_mux;
    assign bus.RAM_DI     = di_mux;
    assign bus.RSP0_VALID = tag_v_q[L-1] & ~tag_id_q[L-1];
    assign bus.RSP1_VALID = tag_v_q[L-1] &  tag_id_q[L-1];
    assign bus.RSP0_DATA  = bus.RAM_DO;
    assign bus.RSP1_DATA  = bus.RAM_DO;
endmodule
